// File: rtl/seg_pkg.sv
// ============================================================================
// Module : seg_pkg
// Brief  : Shared types, constants and hex-to-segment table for the display scan.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] value);
        hex2seg = SEG_BLANK;
        case (value)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            4'hF: hex2seg = 7'h0E;
            default: hex2seg = SEG_BLANK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module : seg7_decode
// Brief  : Combinational 4-bit hex to active-low seven-segment decoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex2seg(hex);

endmodule

`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
// ============================================================================
// Module : seg_scan_scheduler
// Brief  : 8-digit seven-segment scan with per-slot blanking, digit register
//          file and rotating scroll offset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 125000,
    parameter int BLANK_CYC   = 8,
    parameter int SCROLL_DIV  = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [2:0] sel,
    input  logic [3:0] num,
    input  logic       direction,
    input  logic       scroll_en,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       frame_tick,
    output logic       scroll_tick
);

    localparam int ON_CYC = REFRESH_DIV - BLANK_CYC;
    localparam int PH_W   = $clog2(REFRESH_DIV);
    localparam int SCR_W  = $clog2(SCROLL_DIV);

    localparam logic [PH_W-1:0]  C_BLANK_LAST  = PH_W'(BLANK_CYC - 1);
    localparam logic [PH_W-1:0]  C_ON_LAST     = PH_W'(ON_CYC - 1);
    localparam logic [SCR_W-1:0] C_SCROLL_LAST = SCR_W'(SCROLL_DIV - 1);

    logic [3:0]       r_regfile [8];
    scan_state_t      r_state, w_state_nxt;
    logic [PH_W-1:0]  r_phase_cnt, w_phase_cnt_nxt;
    logic [2:0]       r_slot, w_slot_nxt;
    logic [2:0]       r_offset, w_offset_nxt;
    logic [2:0]       r_offset_l;
    logic [2:0]       w_addr;
    logic [SCR_W-1:0] r_scroll_cnt;
    logic             w_scroll_tc;
    logic             w_blank_entry;
    logic             w_frame_end;
    logic [7:0]       w_an_nxt;
    logic [6:0]       w_seg_dec;
    logic [6:0]       r_seg;
    logic [7:0]       r_an;
    logic             r_frame_tick;

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_cnt_nxt = r_phase_cnt + PH_W'(1);
        w_slot_nxt      = r_slot;
        w_blank_entry   = 1'b0;
        w_frame_end     = 1'b0;
        w_an_nxt        = AN_OFF;
        case (r_state)
            BLANK: begin
                if (r_phase_cnt == C_BLANK_LAST) begin
                    w_state_nxt     = ON;
                    w_phase_cnt_nxt = '0;
                end
            end
            ON: begin
                w_an_nxt = ~(8'd1 << r_slot);
                if (r_phase_cnt == C_ON_LAST) begin
                    w_state_nxt     = BLANK;
                    w_phase_cnt_nxt = '0;
                    w_slot_nxt      = r_slot + 3'd1;
                    w_blank_entry   = 1'b1;
                    w_frame_end     = (r_slot == 3'd7);
                end
            end
            default: w_state_nxt = BLANK;
        endcase
    end

    always_comb begin
        w_scroll_tc  = (r_scroll_cnt == C_SCROLL_LAST);
        w_offset_nxt = r_offset;
        if (w_scroll_tc && scroll_en) begin
            w_offset_nxt = direction ? (r_offset + 3'd1) : (r_offset - 3'd1);
        end
    end

    assign w_addr = r_slot + r_offset_l;

    seg7_decode u_decode (
        .hex (r_regfile[w_addr]),
        .seg (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= BLANK;
            r_phase_cnt  <= '0;
            r_slot       <= '0;
            r_offset     <= '0;
            r_offset_l   <= '0;
            r_scroll_cnt <= '0;
            r_seg        <= SEG_BLANK;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase_cnt  <= w_phase_cnt_nxt;
            r_slot       <= w_slot_nxt;
            r_offset     <= w_offset_nxt;
            // Latch the post-tick offset so a scroll coinciding with a slot change lands on the new slot
            if (w_blank_entry) begin
                r_offset_l <= w_offset_nxt;
            end
            r_scroll_cnt <= w_scroll_tc ? '0 : (r_scroll_cnt + SCR_W'(1));
            r_seg        <= w_seg_dec;
            r_an         <= w_an_nxt;
            r_frame_tick <= w_frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regfile[i] <= '0;
            end
        end else if (write) begin
            r_regfile[sel] <= num;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_tick  = r_frame_tick;
    assign scroll_tick = w_scroll_tc;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
// ============================================================================
// Module : tb_seg_scan_scheduler
// Brief  : Directed self-checking bench for seg_scan_scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [2:0] sel;
    logic [3:0] num;
    logic       direction;
    logic       scroll_en;
    logic [6:0] seg;
    logic [7:0] an;
    logic       frame_tick;
    logic       scroll_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [3:0] vals [8] = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h1, 4'h0};
    logic [6:0] segx [8] = '{7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h79, 7'h40};

    seg_scan_scheduler #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .SCROLL_DIV  (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .sel         (sel),
        .num         (num),
        .direction   (direction),
        .scroll_en   (scroll_en),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick),
        .scroll_tick (scroll_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic test_reset();
        reset = 1'b0; write = 1'b1; sel = 3'd0; num = 4'h8;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_chk++; if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an got %h exp ff", an); end
        n_chk++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h exp 7f", seg); end
        n_chk++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
        n_chk++; if (scroll_tick !== 1'b0) begin n_fail++; $display("FAIL reset_scroll_tick got %b exp 0", scroll_tick); end
        reset = 1'b1; write = 1'b0; cyc = 0;
        run_to(1);
        n_chk++; if (an !== 8'hFF) begin n_fail++; $display("FAIL rel_an_e1 got %h exp ff", an); end
        run_to(2);
        n_chk++; if (an !== 8'hFF) begin n_fail++; $display("FAIL rel_an_e2 got %h exp ff", an); end
        run_to(3);
        n_chk++; if (an !== 8'hFE) begin n_fail++; $display("FAIL rel_an_e3 got %h exp fe", an); end
        n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL rel_seg_e3 got %h exp 40", seg); end
        run_to(10);
        n_chk++; if (an !== 8'hFF) begin n_fail++; $display("FAIL rel_an_e10 got %h exp ff", an); end
        run_to(11);
        n_chk++; if (an !== 8'hFD) begin n_fail++; $display("FAIL rel_an_e11 got %h exp fd", an); end
    endtask

    task automatic test_load();
        int ft_cnt;
        int i;
        logic [7:0] exp_an;
        for (int k = 0; k < 8; k++) begin
            write = 1'b1; sel = 3'(k); num = vals[k];
            step();
        end
        write = 1'b0;
        ft_cnt = 0;
        while (cyc < 128) begin
            step();
            if (frame_tick === 1'b1) ft_cnt++;
            if (cyc >= 64 && (cyc % 8) == 5) begin
                i = (cyc - 64) / 8;
                exp_an = ~(8'h01 << i);
                n_chk++; if (an !== exp_an) begin n_fail++; $display("FAIL load_an slot %0d got %h exp %h", i, an, exp_an); end
                n_chk++; if (seg !== segx[i]) begin n_fail++; $display("FAIL load_seg slot %0d got %h exp %h", i, seg, segx[i]); end
            end
            if (cyc == 64) begin
                n_chk++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL frame_tick_c64 got %b exp 1", frame_tick); end
            end
        end
        n_chk++; if (ft_cnt != 2) begin n_fail++; $display("FAIL frame_tick_count got %0d exp 2", ft_cnt); end
    endtask

    task automatic test_scroll_up();
        direction = 1'b1; scroll_en = 1'b1;
        run_to(190);
        n_chk++; if (scroll_tick !== 1'b0) begin n_fail++; $display("FAIL scroll_tick_c190 got %b exp 0", scroll_tick); end
        run_to(191);
        n_chk++; if (scroll_tick !== 1'b1) begin n_fail++; $display("FAIL scroll_tick_c191 got %b exp 1", scroll_tick); end
        run_to(197);
        n_chk++; if (seg !== 7'h21) begin n_fail++; $display("FAIL up1_slot0_seg got %h exp 21", seg); end
        n_chk++; if (an !== 8'hFE) begin n_fail++; $display("FAIL up1_slot0_an got %h exp fe", an); end
        run_to(221);
        n_chk++; if (seg !== 7'h08) begin n_fail++; $display("FAIL up1_slot3_seg got %h exp 08", seg); end
        run_to(645);
        n_chk++; if (seg !== 7'h06) begin n_fail++; $display("FAIL up8_slot0_seg got %h exp 06", seg); end
    endtask

    task automatic test_scroll_down_wrap();
        direction = 1'b0;
        run_to(709);
        n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL down_slot0_seg got %h exp 40", seg); end
        run_to(717);
        n_chk++; if (seg !== 7'h06) begin n_fail++; $display("FAIL down_slot1_seg got %h exp 06", seg); end
    endtask

    task automatic test_live_write();
        direction = 1'b1;
        run_to(770);
        scroll_en = 1'b0;
        run_to(796);
        n_chk++; if (seg !== 7'h03) begin n_fail++; $display("FAIL live_pre_seg got %h exp 03", seg); end
        n_chk++; if (an !== 8'hF7) begin n_fail++; $display("FAIL live_pre_an got %h exp f7", an); end
        write = 1'b1; sel = 3'd3; num = 4'hF;
        step();
        write = 1'b0;
        n_chk++; if (seg !== 7'h03) begin n_fail++; $display("FAIL live_edge_seg got %h exp 03", seg); end
        step();
        n_chk++; if (seg !== 7'h0E) begin n_fail++; $display("FAIL live_post_seg got %h exp 0e", seg); end
        n_chk++; if (an !== 8'hF7) begin n_fail++; $display("FAIL live_post_an got %h exp f7", an); end
    endtask

    task automatic test_mid_on_reset();
        scroll_en = 1'b1; direction = 1'b1;
        run_to(900);
        scroll_en = 1'b0;
        run_to(941);
        n_chk++; if (an !== 8'hDF) begin n_fail++; $display("FAIL pre_rst_an got %h exp df", an); end
        n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL pre_rst_seg got %h exp 40", seg); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_chk++; if (an !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_an got %h exp ff", an); end
        n_chk++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL mid_rst_seg got %h exp 7f", seg); end
        n_chk++; if (frame_tick !== 1'b0 || scroll_tick !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ticks got %b%b exp 00", frame_tick, scroll_tick); end
        run_to(946);
        n_chk++; if (an !== 8'hFE) begin n_fail++; $display("FAIL post_rst_an got %h exp fe", an); end
        n_chk++; if (seg !== 7'h40) begin n_fail++; $display("FAIL post_rst_seg got %h exp 40", seg); end
        write = 1'b1; sel = 3'd2; num = 4'h5;
        step();
        write = 1'b0;
        run_to(963);
        n_chk++; if (seg !== 7'h12) begin n_fail++; $display("FAIL post_rst_slot2_seg got %h exp 12", seg); end
        n_chk++; if (an !== 8'hFB) begin n_fail++; $display("FAIL post_rst_slot2_an got %h exp fb", an); end
        run_to(1004);
        n_chk++; if (scroll_tick !== 1'b0) begin n_fail++; $display("FAIL post_rst_stick_pre got %b exp 0", scroll_tick); end
        run_to(1005);
        n_chk++; if (scroll_tick !== 1'b1) begin n_fail++; $display("FAIL post_rst_stick got %b exp 1", scroll_tick); end
    endtask

    initial begin
        reset = 1'b0; write = 1'b0; sel = 3'd0; num = 4'h0;
        direction = 1'b0; scroll_en = 1'b0;
        test_reset();
        test_load();
        test_scroll_up();
        test_scroll_down_wrap();
        test_live_write();
        test_mid_on_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
